// File: rtl/aes_inv_sub_bytes_seq_pkg.sv
// Shared AES definitions for the inverse SubBytes stage: bSbox mode values, state widths,
// FSM state type and the GF(2^8) helpers behind the S-box lanes.
`ifndef AES_INCLUDE_DEFS
`define AES_INCLUDE_DEFS
`define ENCRIPT 1'b1
`define DECRIPT 1'b0
`define AES_STATE_W 128
`define AES_BYTE_W 8
`endif

package aes_inv_sub_bytes_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] v);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] v);
        return rotl8(v, 1) ^ rotl8(v, 3) ^ rotl8(v, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes_inv_shift_rows.sv
// Combinational AES InvShiftRows: row r of the 4x4 state is rotated right by r columns.
module aes_inv_shift_rows (
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    // Byte k sits at row k%4, column k/4 and moves to column (c+r)%4 of the same row.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int R   = k % 4;
        localparam int C   = k / 4;
        localparam int DST = R + 4 * ((C + R) % 4);
        assign state_out[127-8*DST -: 8] = state_in[127-8*k -: 8];
    end

endmodule

// File: rtl/bSbox.sv
// Shared forward/inverse AES S-box: encrypt=`ENCRIPT gives SubBytes, `DECRIPT gives InvSubBytes.
module bSbox
    import aes_inv_sub_bytes_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic       encrypt,
    output logic [7:0] q
);

    always_comb begin
        if (encrypt) q = affine_fwd(gf_inv(a));
        else         q = gf_inv(affine_inv(a));
    end

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Decrypt-direction SubBytes stage processing LANES bytes per cycle through shared bSbox lanes.
// Define AES_INV_SHIFT_ROWS_EN to apply InvShiftRows to the state as it is loaded.
module aes_inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    import aes_inv_sub_bytes_seq_pkg::*;

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_inv_sub_bytes_seq: LANES=%0d is illegal, use 1, 2, 4, 8 or 16", LANES);
    end

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [`AES_STATE_W-1:0] work_q, work_d;
    logic [`AES_STATE_W-1:0] out_state_q, out_state_d;
    logic [`AES_STATE_W-1:0] load_state;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [3:0]              base;
    logic [`AES_BYTE_W-1:0]  lane_in  [LANES];
    logic [`AES_BYTE_W-1:0]  lane_out [LANES];

`ifdef AES_INV_SHIFT_ROWS_EN
    aes_inv_shift_rows u_inv_shift_rows (
        .state_in  (in_state),
        .state_out (load_state)
    );
`else
    assign load_state = in_state;
`endif

    // First byte handled this cycle; lane g works on byte base+g.
    assign base = 4'(int'(cnt_q) * LANES);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g] = work_q[8*(15 - int'(base) - g) +: 8];
        bSbox u_sbox (
            .a       (lane_in[g]),
            .encrypt (`DECRIPT),
            .q       (lane_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = load_state;
                    cnt_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                for (int i = 0; i < LANES; i++) begin
                    work_d[8*(15 - int'(base) - i) +: 8] = lane_out[i];
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they never show a partial result.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        out_state_d = out_valid_d ? work_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Directed bench for aes_inv_sub_bytes_seq: reset, known S-box vectors, backpressure,
// throughput, LANES sweep and an encrypt/decrypt round trip (AES_INV_SHIFT_ROWS_EN aware).
`ifndef ENCRIPT
`define ENCRIPT 1'b1
`endif

module tb_aes_inv_sub_bytes_seq;

    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] PAT_IN  = {4{32'h7CCA7716}};
    localparam logic [127:0] PAT_EXP = {4{32'h011002FF}};
    localparam logic [127:0] ONE_IN  = 128'h637C6363_63636363_63636363_63636363;
`ifdef AES_INV_SHIFT_ROWS_EN
    localparam logic [127:0] ONE_EXP = 128'h00000000_00010000_00000000_00000000;
`else
    localparam logic [127:0] ONE_EXP = 128'h00010000_00000000_00000000_00000000;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;

    logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
    logic [127:0] sw_out_state [4];

    logic [127:0] rt_plain = '0;
    logic [127:0] rt_cipher;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    aes_inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    for (genvar j = 0; j < 4; j++) begin : g_sweep
        aes_inv_sub_bytes_seq #(.LANES((j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? 8 : 16)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (sw_in_ready[j]),
            .in_state  (in_state),
            .out_valid (sw_out_valid[j]),
            .out_ready (out_ready),
            .out_state (sw_out_state[j]),
            .busy      (sw_busy[j])
        );
    end

    for (genvar b = 0; b < 16; b++) begin : g_enc
        bSbox u_enc (
            .a       (rt_plain[127-8*b -: 8]),
            .encrypt (`ENCRIPT),
            .q       (rt_cipher[127-8*b -: 8])
        );
    end

`ifdef AES_INV_SHIFT_ROWS_EN
    function automatic logic [127:0] inv_shift_model(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*((k % 4) + 4 * (((k / 4) + (k % 4)) % 4)) -: 8] = s[127-8*k -: 8];
        end
        return o;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_state(input logic [127:0] s, output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_state = s;
        tick();
        in_valid = 1'b0;
        in_state = {4{$urandom()}};
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        res = out_state;
    endtask

    task automatic test_reset();
        int pause;
        int stale;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, busy, out_state} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b busy=%b st=%h, expected all zero",
                     in_ready, out_valid, busy, out_state);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got rdy=%b busy=%b, expected rdy=1 busy=0", in_ready, busy);
        end

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = ALL_63;
        tick();
        in_valid = 1'b0;
        pause = $urandom_range(1, 3);
        repeat (pause) tick();
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_sub: got vld=%b busy=%b rdy=%b, expected 000", out_valid, busy, in_ready);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_ready: got rdy=%b, expected 1", in_ready);
        end
        stale = 0;
        repeat (8) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
            tick();
        end
        tests_run++;
        if (stale != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_stale: got %0d cycles with output or busy, expected 0", stale);
        end
    endtask

    task automatic test_all_63();
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        send_state(ALL_63, res, lat);
        tests_run++;
        if (res !== '0) begin
            tests_failed++;
            $display("[TB] FAIL all63_data: got %h, expected 0", res);
        end
        tests_run++;
        if (lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL all63_latency: got %0d, expected 4", lat);
        end
        tick();
        tests_run++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL all63_handshake: got vld/rdy/busy=%b%b%b, expected 010", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_pattern();
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        send_state(PAT_IN, res, lat);
        tests_run++;
        if (res !== PAT_EXP || lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL pattern: got %h lat %0d, expected %h lat 4", res, lat, PAT_EXP);
        end
        tick();
    endtask

    task automatic test_single_byte();
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        send_state(ONE_IN, res, lat);
        tests_run++;
        if (res !== ONE_EXP) begin
            tests_failed++;
            $display("[TB] FAIL single_byte: got %h, expected %h", res, ONE_EXP);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] res;
        int lat;
        int bad;
        out_ready = 1'b0;
        send_state(PAT_IN, res, lat);
        tests_run++;
        if (res !== PAT_EXP || lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL bp_first: got %h lat %0d, expected %h lat 4", res, lat, PAT_EXP);
        end
        in_valid = 1'b1;
        in_state = '0;
        bad = 0;
        repeat (10) begin
            tick();
            if (out_state !== PAT_EXP || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles, expected 0", bad);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL bp_handshake: got vld/rdy/busy=%b%b%b, expected 010", out_valid, in_ready, busy);
        end
        tick();
        tests_run++;
        if ({in_ready, busy} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL bp_second_accept: got rdy/busy=%b%b, expected 01", in_ready, busy);
        end
        in_valid = 1'b0;
        in_state = {4{$urandom()}};
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        tests_run++;
        if (out_state !== {16{8'h52}} || lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL bp_second: got %h lat %0d, expected %h lat 4", out_state, lat, {16{8'h52}});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int guard;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = PAT_IN;
        first  = -1;
        second = -1;
        for (int t = 0; t < 16; t++) begin
            if (in_ready && first < 0) first = t;
            else if (in_ready && second < 0) second = t;
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (second - first != 6) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_period: got %0d, expected 6", second - first);
        end
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_lanes_sweep();
        int lat [4];
        logic [127:0] res [4];
        int exp_lat [4];
        exp_lat = '{16, 8, 2, 1};
        for (int j = 0; j < 4; j++) begin
            lat[j] = 0;
            res[j] = '0;
        end
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = PAT_IN;
        tick();
        in_valid = 1'b0;
        in_state = {4{$urandom()}};
        for (int t = 1; t <= 20; t++) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                if (sw_out_valid[j] && lat[j] == 0) begin
                    lat[j] = t;
                    res[j] = sw_out_state[j];
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (res[j] !== PAT_EXP) begin
                tests_failed++;
                $display("[TB] FAIL sweep_data[%0d]: got %h, expected %h", j, res[j], PAT_EXP);
            end
            tests_run++;
            if (lat[j] != exp_lat[j]) begin
                tests_failed++;
                $display("[TB] FAIL sweep_latency[%0d]: got %0d, expected %0d", j, lat[j], exp_lat[j]);
            end
        end
        tests_run++;
        if ({sw_in_ready, sw_busy} !== 8'hF0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_idle: got rdy=%b busy=%b, expected 1111/0000", sw_in_ready, sw_busy);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] res;
        logic [127:0] expv;
        int lat;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rt_plain = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
`ifdef AES_INV_SHIFT_ROWS_EN
            expv = inv_shift_model(rt_plain);
`else
            expv = rt_plain;
`endif
            send_state(rt_cipher, res, lat);
            tests_run++;
            if (res !== expv || lat != 4) begin
                tests_failed++;
                $display("[TB] FAIL round_trip[%0d]: got %h lat %0d, expected %h lat 4", n, res, lat, expv);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_all_63();
        test_pattern();
        test_single_byte();
        test_backpressure();
        test_back_to_back();
        test_round_trip();
        test_lanes_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
